// File: rtl/ysyx_23060201_pkg.sv
// Shared ALU op encodings and arbiter state encoding for the ysyx_23060201 core.
package ysyx_23060201_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_23060201_ALU.sv
// Purely combinational 32-bit ALU; codes it does not decode produce zero.
module ysyx_23060201_ALU
  import ysyx_23060201_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctl,
  output logic [31:0] res
);

  logic [4:0] shamt;

  always_comb begin
    shamt = b[4:0];
    res   = '0;
    case (ctl)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  res = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'd0, a < b};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the EXU (requester 0) and LSU (requester 1).
module ysyx_23060201_alu_arbiter
  import ysyx_23060201_pkg::*;
#(
  parameter int W    = 32,
  parameter int CTLW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_0,
  input  logic            req_valid_1,
  output logic            req_ready_0,
  output logic            req_ready_1,
  input  logic [W-1:0]    req_a_0,
  input  logic [W-1:0]    req_a_1,
  input  logic [W-1:0]    req_b_0,
  input  logic [W-1:0]    req_b_1,
  input  logic [CTLW-1:0] req_ctl_0,
  input  logic [CTLW-1:0] req_ctl_1,
  output logic            resp_valid_0,
  output logic            resp_valid_1,
  input  logic            resp_ready_0,
  input  logic            resp_ready_1,
  output logic [W-1:0]    resp_res,
  output logic            busy
);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CTLW-1:0] ctl_q, ctl_d;
  logic [W-1:0]    res_q, res_d;

  logic [W-1:0]    alu_res;
  logic            owner_resp_ready;
  logic            can_accept;
  logic            winner;
  logic            grant_0;
  logic            grant_1;
  logic            req_hs;

  ysyx_23060201_ALU u_alu (
    .a   (a_q),
    .b   (b_q),
    .ctl (ctl_q),
    .res (alu_res)
  );

  // A grant is possible in IDLE, or in RESP when the owner drains its result the same cycle.
  always_comb begin
    owner_resp_ready = owner_q ? resp_ready_1 : resp_ready_0;
    can_accept       = !rst && ((state_q == ST_IDLE) ||
                                ((state_q == ST_RESP) && owner_resp_ready));
    winner           = (req_valid_0 && req_valid_1) ? ~last_q : req_valid_1;
    grant_0          = can_accept && req_valid_0 && !winner;
    grant_1          = can_accept && req_valid_1 && winner;
    req_hs           = grant_0 || grant_1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: if (req_hs) state_d = ST_EXEC;
      ST_EXEC: begin
        res_d   = alu_res;
        state_d = ST_RESP;
      end
      ST_RESP: if (owner_resp_ready) state_d = req_hs ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (req_hs) begin
      owner_d = winner;
      last_d  = winner;
      a_d     = winner ? req_a_1   : req_a_0;
      b_d     = winner ? req_b_1   : req_b_0;
      ctl_d   = winner ? req_ctl_1 : req_ctl_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
    end
  end

  assign req_ready_0  = grant_0;
  assign req_ready_1  = grant_1;
  assign resp_valid_0 = (state_q == ST_RESP) && !owner_q;
  assign resp_valid_1 = (state_q == ST_RESP) && owner_q;
  assign resp_res     = res_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_23060201_alu_arbiter.sv
// Self-checking bench for the shared-ALU arbiter: vector table, corner sequences, random traffic.
module tb_ysyx_23060201_alu_arbiter;
  import ysyx_23060201_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [3:0]  req_ctl_0, req_ctl_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0, resp_ready_1;
  logic [31:0] resp_res;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  ysyx_23060201_alu_arbiter #(.W(32), .CTLW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (req_valid_0),
    .req_valid_1  (req_valid_1),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .req_a_0      (req_a_0),
    .req_a_1      (req_a_1),
    .req_b_0      (req_b_0),
    .req_b_1      (req_b_1),
    .req_ctl_0    (req_ctl_0),
    .req_ctl_1    (req_ctl_1),
    .resp_valid_0 (resp_valid_0),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_0 (resp_ready_0),
    .resp_ready_1 (resp_ready_1),
    .resp_res     (resp_res),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference ALU written from the op definitions, not the RTL structure.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    int unsigned sh;
    sh = b & 32'd31;
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + (~b) + 32'd1;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic drive_req(input int who, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
    if (who == 0) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_ctl_0 = c;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_ctl_1 = c;
    end
  endtask

  // One isolated op from IDLE with the response drained immediately.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    resp_ready_0 = 1'b1;
    resp_ready_1 = 1'b1;
    req_valid_0  = 1'b0;
    req_valid_1  = 1'b0;
    drive_req(v.who, 1'b1, v.a, v.b, v.ctl);
    #1;
    checkOutput("vec_ready_winner", (v.who == 1) ? req_ready_1 : req_ready_0, 1);
    checkOutput("vec_ready_other",  (v.who == 1) ? req_ready_0 : req_ready_1, 0);
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    checkOutput("vec_exec_quiet", {30'd0, resp_valid_1, resp_valid_0}, 0);
    checkOutput("vec_exec_busy", busy, 1);
    @(negedge clk);
    checkOutput("vec_resp_valid", (v.who == 1) ? resp_valid_1 : resp_valid_0, 1);
    checkOutput("vec_resp_other", (v.who == 1) ? resp_valid_0 : resp_valid_1, 0);
    checkOutput("vec_resp_res", resp_res, v.exp);
  endtask

  logic        pend[2];
  logic [31:0] pa[2], pb[2];
  logic [3:0]  pc[2];
  logic [3:0]  ops[11];
  int          model_last;
  logic [31:0] exp_res;

  initial begin
    vecs[0]  = '{0, 32'd5,          32'd7,          ALU_ADD,  32'd12};
    vecs[1]  = '{1, 32'd3,          32'd5,          ALU_SUB,  32'hFFFF_FFFE};
    vecs[2]  = '{0, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  ALU_XOR,  32'hFFFF_FFFF};
    vecs[3]  = '{1, 32'h00FF_0000,  32'h0000_FF00,  ALU_OR,   32'h00FF_FF00};
    vecs[4]  = '{0, 32'hDEAD_BEEF,  32'hFFFF_0000,  ALU_AND,  32'hDEAD_0000};
    vecs[5]  = '{1, 32'd1,          32'd31,         ALU_SLL,  32'h8000_0000};
    vecs[6]  = '{0, 32'h8000_0000,  32'd4,          ALU_SRL,  32'h0800_0000};
    vecs[7]  = '{1, 32'h8000_0000,  32'd4,          ALU_SRA,  32'hF800_0000};
    vecs[8]  = '{0, 32'hFFFF_FFFF,  32'd1,          ALU_SLT,  32'd1};
    vecs[9]  = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 32'd0};
    vecs[10] = '{0, 32'd1,          32'd1,          4'b1111,  32'd0};
    vecs[11] = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD,  32'd0};
    vecs[12] = '{0, 32'h1234_5678,  32'h24,         ALU_SLL,  32'h2345_6780};
    ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL,
            ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, 4'b1111};

    rst = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0;
    req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
    req_ctl_0 = 0; req_ctl_1 = 0;
    resp_ready_0 = 0; resp_ready_1 = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready",  {30'd0, req_ready_1, req_ready_0}, 0);
    checkOutput("reset_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 0);
    checkOutput("reset_resp_res", resp_res, 0);
    checkOutput("reset_busy", busy, 0);

    // Both requesters hold requests continuously: grants must alternate starting with 0.
    $display("[TB] round-robin with both requesters valid");
    rst = 1'b0;
    resp_ready_0 = 1; resp_ready_1 = 1;
    drive_req(0, 1'b1, 32'd1,  32'd2, ALU_ADD);
    drive_req(1, 1'b1, 32'd10, 32'd3, ALU_SUB);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = -1;
      for (int t = 0; t < 6; t++) begin
        #1;
        checkOutput("rr_single_ready", req_ready_0 & req_ready_1, 0);
        if (req_ready_0 ^ req_ready_1) begin
          w = req_ready_1 ? 1 : 0;
          break;
        end
        @(negedge clk);
      end
      if (w < 0) begin
        checkOutput("rr_grant_timeout", 0, 1);
        break;
      end
      checkOutput("rr_order", w, k % 2);
      @(negedge clk);
      checkOutput("rr_exec_quiet", {30'd0, resp_valid_1, resp_valid_0}, 0);
      @(negedge clk);
      checkOutput("rr_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, (w == 1) ? 2 : 1);
      checkOutput("rr_resp_res", resp_res, (w == 1) ? 32'd7 : 32'd3);
    end
    req_valid_0 = 0; req_valid_1 = 0;
    @(negedge clk);
    checkOutput("rr_idle_after", busy, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // Result held under backpressure, then a back-to-back grant on release.
    $display("[TB] backpressure and back-to-back");
    @(negedge clk);
    resp_ready_0 = 0; resp_ready_1 = 1;
    drive_req(0, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, ALU_XOR);
    #1;
    checkOutput("bp_ready0", req_ready_0, 1);
    @(negedge clk);
    drive_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD);
    drive_req(1, 1'b1, 32'd100, 32'd58, ALU_SUB);
    #1;
    checkOutput("bp_exec_ready1", req_ready_1, 0);
    @(negedge clk);
    repeat (5) begin
      checkOutput("bp_hold_valid", resp_valid_0, 1);
      checkOutput("bp_hold_other", resp_valid_1, 0);
      checkOutput("bp_hold_res", resp_res, 32'hFFFF_FFFF);
      checkOutput("bp_hold_ready", {30'd0, req_ready_1, req_ready_0}, 0);
      @(negedge clk);
    end
    resp_ready_0 = 1;
    #1;
    checkOutput("b2b_ready1", req_ready_1, 1);
    checkOutput("b2b_still_valid", resp_valid_0, 1);
    @(negedge clk);
    req_valid_1 = 0;
    checkOutput("b2b_exec_quiet", {30'd0, resp_valid_1, resp_valid_0}, 0);
    checkOutput("b2b_exec_busy", busy, 1);
    @(negedge clk);
    checkOutput("b2b_resp_valid1", resp_valid_1, 1);
    checkOutput("b2b_resp_res", resp_res, 32'd42);

    // Reset while the op is executing discards it; first tie afterwards goes to 0.
    $display("[TB] reset during EXEC");
    @(negedge clk);
    drive_req(0, 1'b1, 32'd9, 32'd9, ALU_ADD);
    #1;
    checkOutput("rst_op_ready0", req_ready_0, 1);
    @(negedge clk);
    rst = 1'b1;
    drive_req(0, 1'b1, 32'd6, 32'd7, ALU_AND);
    drive_req(1, 1'b1, 32'd2, 32'd2, ALU_ADD);
    #1;
    checkOutput("rst_gates_ready", {30'd0, req_ready_1, req_ready_0}, 0);
    @(negedge clk);
    checkOutput("rst_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 0);
    checkOutput("rst_resp_res", resp_res, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_tie_winner", {30'd0, req_ready_1, req_ready_0}, 1);
    @(negedge clk);
    req_valid_0 = 0; req_valid_1 = 0;
    checkOutput("rst_no_stale_resp", {30'd0, resp_valid_1, resp_valid_0}, 0);
    @(negedge clk);
    checkOutput("rst_new_resp", resp_valid_0, 1);
    checkOutput("rst_new_res", resp_res, 32'd6);
    @(negedge clk);
    model_last = 0;

    // Random traffic with pending requests held until granted and random backpressure.
    $display("[TB] random traffic");
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      int w;
      int d;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1; pa[r] = $urandom; pb[r] = $urandom; pc[r] = ops[$urandom_range(0, 10)];
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = int'($urandom_range(0, 1));
        pend[w] = 1; pa[w] = $urandom; pb[w] = $urandom; pc[w] = ops[$urandom_range(0, 10)];
      end
      for (int r = 0; r < 2; r++) drive_req(r, pend[r], pa[r], pb[r], pc[r]);
      #1;
      w = (pend[0] && pend[1]) ? (1 - model_last) : (pend[1] ? 1 : 0);
      checkOutput("rand_grant", {30'd0, req_ready_1, req_ready_0}, (w == 1) ? 2 : 1);
      exp_res    = ref_alu(pa[w], pb[w], pc[w]);
      pend[w]    = 0;
      model_last = w;
      @(negedge clk);
      drive_req(w, 1'b0, pa[w], pb[w], pc[w]);
      resp_ready_0 = 0; resp_ready_1 = 0;
      checkOutput("rand_exec_quiet", {30'd0, resp_valid_1, resp_valid_0}, 0);
      @(negedge clk);
      d = int'($urandom_range(0, 2));
      for (int c = 0; c < d; c++) begin
        checkOutput("rand_hold_valid", {30'd0, resp_valid_1, resp_valid_0}, (w == 1) ? 2 : 1);
        checkOutput("rand_hold_res", resp_res, exp_res);
        #1;
        checkOutput("rand_hold_ready", {30'd0, req_ready_1, req_ready_0}, 0);
        @(negedge clk);
      end
      checkOutput("rand_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, (w == 1) ? 2 : 1);
      checkOutput("rand_resp_res", resp_res, exp_res);
      if (w == 1) resp_ready_1 = 1; else resp_ready_0 = 1;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
